muldiv_unit: RTL and testbench

- Parametrised multi-cycle multiply/divide unit with architectural HI/LO registers for the pipelined MIPS core.
- Runs beside the single-cycle ALU in EX: accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO.
- Iterates one bit per cycle and holds `busy` so the hazard unit can stall MFHI/MFLO and further mul/div ops.
- Supports pipeline flush via `cancel`.

---
 rtl/muldiv_if.sv | 25 ++
 rtl/muldiv_unit.sv | 173 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/muldiv_if.sv
// Request/result bundle between the EX stage and the multiply/divide unit.
interface muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cancel;
  logic             busy;
  logic             done;
  logic             div0;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, cancel,
    input  busy, done, div0, hi, lo
  );

  modport slave (
    input  start, op, a, b, cancel,
    output busy, done, div0, hi, lo
  );
endinterface

// File: rtl/muldiv_unit.sv
// Multi-cycle MIPS multiply/divide unit with architectural HI/LO registers.
// Define MULDIV_FAST_MUL_EN for a single-cycle multiplier (divide stays iterative).
//
// state | meaning
// IDLE  | accepts start; MTHI/MTLO write immediately
// RUN   | one multiplier/quotient bit per cycle, counter WIDTH-1 down to 0
// FIX   | sign correction, HI/LO write, done pulse
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     rst_n,
  muldiv_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opb_q, opb_d, a_q, a_d, hi_q, hi_d, lo_q, lo_d;
  logic is_div_q, is_div_d, qneg_q, qneg_d, rneg_q, rneg_d, bzero_q, bzero_d;
  logic busy_q, busy_d, done_q, done_d, div0_q, div0_d;

  logic               op_mul, op_div, op_sgn, a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag, quot, rem;
  logic [WIDTH:0]     mul_sum, div_trial, div_rem;
  logic               div_ge;
  logic [2*WIDTH-1:0] mul_next, div_next, mul_res;

  always_comb begin
    op_mul = (bus.op == 3'd1) || (bus.op == 3'd2);
    op_div = (bus.op == 3'd3) || (bus.op == 3'd4);
    op_sgn = (bus.op == 3'd1) || (bus.op == 3'd3);
    a_neg  = op_sgn & bus.a[WIDTH-1];
    b_neg  = op_sgn & bus.b[WIDTH-1];
    a_mag  = a_neg ? -bus.a : bus.a;
    b_mag  = b_neg ? -bus.b : bus.b;
  end

  // Shift-add keeps the multiplier in the low half and shifts the sum in from the top.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opb_q : '0)};
    mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
    div_trial = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_ge    = div_trial >= {1'b0, opb_q};
    div_rem   = div_ge ? (div_trial - {1'b0, opb_q}) : div_trial;
    div_next  = {div_rem[WIDTH-1:0], acc_q[WIDTH-2:0], div_ge};
    mul_res   = qneg_q ? -acc_q : acc_q;
    quot      = acc_q[WIDTH-1:0];
    rem       = acc_q[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    a_d      = a_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    is_div_d = is_div_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    bzero_d  = bzero_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    div0_d   = div0_q;
    if (bus.cancel) begin
      state_d = IDLE;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            if (op_mul || op_div) begin
              is_div_d = op_div;
              qneg_d   = a_neg ^ b_neg;
              rneg_d   = a_neg;
              bzero_d  = (bus.b == '0);
              a_d      = bus.a;
              opb_d    = op_mul ? a_mag : b_mag;
              acc_d    = {{WIDTH{1'b0}}, (op_mul ? b_mag : a_mag)};
              cnt_d    = CW'(WIDTH - 1);
              state_d  = RUN;
              busy_d   = 1'b1;
`ifdef MULDIV_FAST_MUL_EN
              if (op_mul) begin
                acc_d   = {{WIDTH{1'b0}}, a_mag} * {{WIDTH{1'b0}}, b_mag};
                state_d = FIX;
              end
`endif
            end else if (bus.op == 3'd5) begin
              hi_d = bus.a;
            end else if (bus.op == 3'd6) begin
              lo_d = bus.a;
            end
          end
        end
        RUN: begin
          acc_d = is_div_q ? div_next : mul_next;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == '0) state_d = FIX;
        end
        FIX: begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          if (!is_div_q) begin
            hi_d   = mul_res[2*WIDTH-1:WIDTH];
            lo_d   = mul_res[WIDTH-1:0];
            div0_d = 1'b0;
          end else if (bzero_q) begin
            hi_d   = a_q;
            lo_d   = '1;
            div0_d = 1'b1;
          end else begin
            // MIN/-1 falls out naturally: 2^(WIDTH-1) negated is MIN, remainder 0.
            hi_d   = rneg_q ? -rem : rem;
            lo_d   = qneg_q ? -quot : quot;
            div0_d = 1'b0;
          end
        end
        default: begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opb_q    <= '0;
      a_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      is_div_q <= 1'b0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      bzero_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      div0_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      a_q      <= a_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      is_div_q <= is_div_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      bzero_q  <= bzero_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      div0_q   <= div0_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.div0 = div0_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit (WIDTH=32), hand-computed expectations.
module tb_muldiv_unit;
  localparam int W = 32;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = W + 1;
`endif
  localparam int DIV_LAT = W + 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  muldiv_if #(.WIDTH(W)) bus ();
  muldiv_unit #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int lat;
  logic seen_done;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Called just after a negedge; returns at the negedge following the accepting edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    @(negedge clk);
    bus.start = 1'b0;
    bus.op    = 3'd0;
    acc_cyc   = cyc;
  endtask

  task automatic wait_done(output int l);
    while (bus.done !== 1'b1 && (cyc - acc_cyc) < 100) @(negedge clk);
    l = cyc - acc_cyc;
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int lat_exp, input logic [31:0] hi_exp,
                        input logic [31:0] lo_exp, input logic div0_exp);
    int l;
    issue(op, a, b);
    wait_done(l);
    check({tag, " latency"}, 64'(l), 64'(lat_exp));
    check({tag, " hi"}, 64'(bus.hi), 64'(hi_exp));
    check({tag, " lo"}, 64'(bus.lo), 64'(lo_exp));
    check({tag, " div0"}, 64'(bus.div0), 64'(div0_exp));
    check({tag, " busy at done"}, 64'(bus.busy), 64'd0);
    @(negedge clk);
    check({tag, " done one cycle"}, 64'(bus.done), 64'd0);
  endtask

  initial begin
    bus.start = 1'b0; bus.cancel = 1'b0; bus.op = 3'd0; bus.a = '0; bus.b = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset hi", 64'(bus.hi), 64'd0);
    check("reset lo", 64'(bus.lo), 64'd0);
    check("reset busy", 64'(bus.busy), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset in the middle of a divide
    issue(3'd5, 32'hDEAD, 32'h0);
    check("mthi", 64'(bus.hi), 64'hDEAD);
    issue(3'd6, 32'hBEEF, 32'h0);
    check("mtlo", 64'(bus.lo), 64'hBEEF);
    issue(3'd3, 32'd100, 32'd7);
    check("div busy", 64'(bus.busy), 64'd1);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("rst hi", 64'(bus.hi), 64'd0);
    check("rst lo", 64'(bus.lo), 64'd0);
    check("rst busy", 64'(bus.busy), 64'd0);
    check("rst done", 64'(bus.done), 64'd0);
    check("rst div0", 64'(bus.div0), 64'd0);
    seen_done = 1'b0;
    repeat (40) begin @(negedge clk); seen_done |= bus.done; end
    check("rst no done", 64'(seen_done), 64'd0);
    issue(3'd6, 32'h1234, 32'h0);
    check("mtlo after rst", 64'(bus.lo), 64'h0000_1234);
    check("mtlo no busy", 64'(bus.busy), 64'd0);

    run_op("multu max", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    run_op("mult -3*5", 3'd1, 32'hFFFF_FFFD, 32'd5, MUL_LAT, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
    run_op("div -7/2", 3'd3, 32'hFFFF_FFF9, 32'd2, DIV_LAT, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_op("div 7/-2", 3'd3, 32'd7, 32'hFFFF_FFFE, DIV_LAT, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0);
    run_op("divu 7/2", 3'd4, 32'd7, 32'd2, DIV_LAT, 32'd1, 32'd3, 1'b0);
    run_op("div ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, DIV_LAT, 32'h0, 32'h8000_0000, 1'b0);
    run_op("divu by 0", 3'd4, 32'h55, 32'h0, DIV_LAT, 32'h55, 32'hFFFF_FFFF, 1'b1);
    repeat (3) @(negedge clk);
    check("div0 holds", 64'(bus.div0), 64'd1);
    run_op("mult after div0", 3'd1, 32'd2, 32'd3, MUL_LAT, 32'd0, 32'd6, 1'b0);

    // Cancel on cycle 10 with a simultaneous MTHI
    issue(3'd3, 32'd100, 32'd7);
    repeat (8) @(negedge clk);
    bus.cancel = 1'b1; bus.start = 1'b1; bus.op = 3'd5; bus.a = 32'hAA;
    @(negedge clk);
    bus.cancel = 1'b0; bus.start = 1'b0; bus.op = 3'd0;
    check("cancel busy", 64'(bus.busy), 64'd0);
    check("cancel hi", 64'(bus.hi), 64'd0);
    seen_done = 1'b0;
    repeat (40) begin @(negedge clk); seen_done |= bus.done; end
    check("cancel no done", 64'(seen_done), 64'd0);
    check("cancel lo kept", 64'(bus.lo), 64'd6);
    check("cancel hi kept", 64'(bus.hi), 64'd0);

    // Starts while busy are ignored
    issue(3'd4, 32'd100, 32'd7);
    repeat (3) @(negedge clk);
    bus.start = 1'b1; bus.op = 3'd1; bus.a = 32'd9; bus.b = 32'd9;
    @(negedge clk);
    bus.op = 3'd5; bus.a = 32'h77;
    @(negedge clk);
    bus.start = 1'b0; bus.op = 3'd0;
    wait_done(lat);
    check("busy-ignore latency", 64'(lat), 64'(DIV_LAT));
    check("busy-ignore lo", 64'(bus.lo), 64'd14);
    check("busy-ignore hi", 64'(bus.hi), 64'd2);

    // Back-to-back: next op started in the done cycle
    issue(3'd4, 32'd7, 32'd2);
    wait_done(lat);
    check("b2b first lo", 64'(bus.lo), 64'd3);
    issue(3'd4, 32'd200, 32'd9);
    check("b2b accepted", 64'(bus.busy), 64'd1);
    wait_done(lat);
    check("b2b latency", 64'(lat), 64'(DIV_LAT));
    check("b2b lo", 64'(bus.lo), 64'd22);
    check("b2b hi", 64'(bus.hi), 64'd2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
